expr_checker: RTL and testbench
===============================

# expr_checker

Parametrised, streaming syntax checker for ASCII infix arithmetic expressions with nested parentheses. It consumes one character per accepted clock and continuously reports whether the characters consumed so far form a complete, well-formed expression. It replaces the fixed single-digit checker in the string-recognition datapath and adds the following:
- a configurable nesting-depth counter;
- optional multi-digit operands;
- optional whitespace skipping;
- a sticky error flag with the position of the first offending character.

## Interface
- DEPTH_W, 4: width of the nesting-depth counter; maximum depth is MAX_DEPTH = 2^DEPTH_W - 1.
- POS_W, 8: width of the character-position counter and of err_pos.
- MULTI_DIGIT, 0: 1 = consecutive digits form one operand; 0 = a digit directly after a digit is an error.
- SKIP_SPACE, 0: 1 = ASCII space (8'h20) is consumed with no effect; 0 = space is an illegal character.
- clk  in  1  single clock; all state updates on the rising edge.
- clr  in  1  synchronous, active-high reset; has priority over everything.
- in_valid  in  1  when 1, in is consumed this edge; when 0, all state holds.
- in  in  8  ASCII character.
- out  out  1  1 = the prefix consumed so far is a complete valid expression.
- err  out  1  sticky syntax error; held until clr.
- depth  out  DEPTH_W  current count of open parentheses.
- err_pos  out  POS_W  zero-based index of the first offending character; valid while err=1.

## Operation
- Grammar: expr := term (op term)*; term := number | '(' expr ')'; op in {'+','-','*','/'}; number := '0'-'9' (one or more when MULTI_DIGIT=1).
- State machine states: OPND (expecting operand), OPR (operand just completed), ERR.
- OPND transitions:
  - digit -> OPR.
  - '(' -> OPND and depth+1, unless depth == MAX_DEPTH, which -> ERR (overflow).
  - anything else -> ERR.
- OPR transitions:
  - op -> OPND.
  - ')' with depth > 0 -> OPR and depth-1.
  - ')' with depth == 0 -> ERR (unmatched).
  - digit -> OPR if MULTI_DIGIT=1, else ERR.
  - anything else -> ERR.
- Space handling: when SKIP_SPACE=1, space causes no state or depth change in OPND and OPR, but pos still increments. When MULTI_DIGIT=1, "1 2" is still accepted (a space does not terminate a number).
- ERR is absorbing: only clr leaves it. depth and pos freeze on entry.
- pos: internal POS_W counter of consumed characters, incremented on every accepted character while not in ERR. It saturates at 2^POS_W - 1 (no wrap).
- On the transition into ERR, err_pos <= pos (the index of the offending character).
- out = (state == OPR) && (depth == 0). It is derived from registered state only, so there is no combinational path from in.
- err = (state == ERR).

## Timing
- Reset (clr=1 at an edge):
  - state = OPND, depth = 0, pos = 0, err_pos = 0;
  - out = 0, err = 0 after that edge;
  - applies mid-expression, and in the same cycle as in_valid=1 (the character is dropped).
- Latency: a character sampled at edge k is reflected in out/err/depth immediately after edge k, i.e. one cycle.
- Throughput: one character per cycle; no backpressure.
- in_valid=0: no change to any register, including pos.
- Empty input: out=0 (state OPND).
- Boundary cases:
  - "()": ')' arrives in OPND -> ERR.
  - trailing op: out=0, no error (incomplete, not illegal).
  - unclosed '(': out=0, no error.

## Test plan
- Default parameters, stream "1+(1+2*1+2)*(3)" one char per cycle: out sequence 1,0,0,0,0,0,0,0,0,0,1,0,0,0,1; depth peaks at 1; err stays 0.
- Stream "1+)": err=1 after the third edge, err_pos=2, out=0. Further valid characters leave err=1 and err_pos=2.
- DEPTH_W=2, stream "((((": depth reaches 3 after the third '(', then err=1 with err_pos=3 and depth frozen at 3.
- "12+3":
  - MULTI_DIGIT=0: err=1, err_pos=1.
  - MULTI_DIGIT=1: out=1 after '2', 0 after '+', 1 after '3', err=0.
- SKIP_SPACE=1, "( 7 )" with in_valid low for 2 cycles between chars: out=1 only after ')', depth 1 then 0. With SKIP_SPACE=0, the same stream gives err_pos=1.
- Assert clr together with in_valid and '(' in the middle of "(1+": next cycle depth=0, out=0, err=0. Then "5" -> out=1.

Source files
------------

// File: rtl/expr_checker.sv
// Streaming syntax checker for ASCII infix expressions with nested parentheses.
// Reports a complete, well-formed prefix on out; a sticky err flag holds the index of the first bad character.
module expr_checker #(
    parameter int unsigned DEPTH_W     = 4,
    parameter int unsigned POS_W       = 8,
    parameter int unsigned MULTI_DIGIT = 0,
    parameter int unsigned SKIP_SPACE  = 0
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               out,
    output logic               err,
    output logic [DEPTH_W-1:0] depth,
    output logic [POS_W-1:0]   err_pos
);

    localparam logic [DEPTH_W-1:0] MAX_DEPTH = '1;
    localparam logic [POS_W-1:0]   MAX_POS   = '1;
    localparam bit                 MD_EN     = (MULTI_DIGIT != 0);
    localparam bit                 SP_EN     = (SKIP_SPACE != 0);

    typedef enum logic [1:0] {
        OPND = 2'd0,
        OPR  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t             state;
    state_t             nxt_state;
    logic [DEPTH_W-1:0] nxt_depth;
    logic [POS_W-1:0]   pos;
    logic [POS_W-1:0]   nxt_pos;
    logic [POS_W-1:0]   nxt_err_pos;

    logic is_digit;
    logic is_op;
    logic is_lparen;
    logic is_rparen;
    logic is_space;

    // Character classification
    always_comb begin
        is_digit  = (in >= 8'h30) && (in <= 8'h39);
        is_op     = (in == 8'h2B) || (in == 8'h2D) || (in == 8'h2A) || (in == 8'h2F);
        is_lparen = (in == 8'h28);
        is_rparen = (in == 8'h29);
        is_space  = (in == 8'h20);
    end

    // Next-state, depth and position logic
    always_comb begin
        nxt_state   = state;
        nxt_depth   = depth;
        nxt_pos     = pos;
        nxt_err_pos = err_pos;
        if (in_valid && (state != ERR)) begin
            if (pos != MAX_POS) begin
                nxt_pos = pos + POS_W'(1);
            end
            if (!(SP_EN && is_space)) begin
                case (state)
                    OPND: begin
                        if (is_digit) begin
                            nxt_state = OPR;
                        end else if (is_lparen && (depth != MAX_DEPTH)) begin
                            nxt_depth = depth + DEPTH_W'(1);
                        end else begin
                            nxt_state = ERR;
                        end
                    end
                    OPR: begin
                        if (is_op) begin
                            nxt_state = OPND;
                        end else if (is_rparen && (depth != '0)) begin
                            nxt_depth = depth - DEPTH_W'(1);
                        end else if (!(is_digit && MD_EN)) begin
                            nxt_state = ERR;
                        end
                    end
                    default: begin
                        nxt_state = state;
                    end
                endcase
            end
            if (nxt_state == ERR) begin
                nxt_err_pos = pos;
                nxt_pos     = pos;
            end
        end
    end

    // State and registered outputs; out/err track the state being entered
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= OPND;
            depth   <= '0;
            pos     <= '0;
            err_pos <= '0;
            out     <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= nxt_state;
            depth   <= nxt_depth;
            pos     <= nxt_pos;
            err_pos <= nxt_err_pos;
            out     <= (nxt_state == OPR) && (nxt_depth == '0);
            err     <= (nxt_state == ERR);
        end
    end

endmodule

// File: tb/tb_expr_checker.sv
// Directed bench for expr_checker across four parameter sets sharing one input stream.
module tb_expr_checker;

    logic       clk = 1'b0;
    logic       clr;
    logic       in_valid;
    logic [7:0] in;

    logic       out_def, err_def, out_d2, err_d2, out_md, err_md, out_sp, err_sp;
    logic [3:0] depth_def, depth_md, depth_sp;
    logic [1:0] depth_d2;
    logic [7:0] ep_def, ep_d2, ep_md, ep_sp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    expr_checker u_def (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(out_def), .err(err_def), .depth(depth_def), .err_pos(ep_def)
    );
    expr_checker #(.DEPTH_W(2)) u_d2 (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(out_d2), .err(err_d2), .depth(depth_d2), .err_pos(ep_d2)
    );
    expr_checker #(.MULTI_DIGIT(1)) u_md (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(out_md), .err(err_md), .depth(depth_md), .err_pos(ep_md)
    );
    expr_checker #(.SKIP_SPACE(1)) u_sp (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(out_sp), .err(err_sp), .depth(depth_sp), .err_pos(ep_sp)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        in       = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        string s;
        string exp_out;
        int    max_d;

        clr      = 1'b0;
        in_valid = 1'b0;
        in       = 8'h00;
        reset_dut();
        chk("rst_out", 32'(out_def), 32'd0);
        chk("rst_err", 32'(err_def), 32'd0);
        chk("rst_depth", 32'(depth_def), 32'd0);
        chk("rst_errpos", 32'(ep_def), 32'd0);

        // Main nested expression, out checked after every character
        s       = "1+(1+2*1+2)*(3)";
        exp_out = "100000000010001";
        max_d   = 0;
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            chk($sformatf("main_out[%0d]", i), 32'(out_def), (exp_out[i] == "1") ? 32'd1 : 32'd0);
            if (int'(depth_def) > max_d) max_d = int'(depth_def);
        end
        chk("main_peak_depth", 32'(max_d), 32'd1);
        chk("main_err", 32'(err_def), 32'd0);

        // Unmatched close paren, then sticky behaviour
        reset_dut();
        send("1"); send("+"); send(")");
        chk("unm_err", 32'(err_def), 32'd1);
        chk("unm_errpos", 32'(ep_def), 32'd2);
        chk("unm_out", 32'(out_def), 32'd0);
        send("1"); send("+"); send("2");
        chk("unm_sticky_err", 32'(err_def), 32'd1);
        chk("unm_sticky_pos", 32'(ep_def), 32'd2);
        chk("unm_sticky_out", 32'(out_def), 32'd0);

        // Depth overflow with DEPTH_W=2
        reset_dut();
        send("("); send("("); send("(");
        chk("ovf_depth3", 32'(depth_d2), 32'd3);
        chk("ovf_noerr", 32'(err_d2), 32'd0);
        send("(");
        chk("ovf_err", 32'(err_d2), 32'd1);
        chk("ovf_errpos", 32'(ep_d2), 32'd3);
        chk("ovf_depth_frozen", 32'(depth_d2), 32'd3);
        chk("ovf_def_depth4", 32'(depth_def), 32'd4);
        chk("ovf_def_noerr", 32'(err_def), 32'd0);

        // Multi-digit operands
        reset_dut();
        send("1");
        chk("md_out_1", 32'(out_md), 32'd1);
        send("2");
        chk("md_out_2", 32'(out_md), 32'd1);
        chk("sd_err", 32'(err_def), 32'd1);
        chk("sd_errpos", 32'(ep_def), 32'd1);
        send("+");
        chk("md_out_plus", 32'(out_md), 32'd0);
        send("3");
        chk("md_out_3", 32'(out_md), 32'd1);
        chk("md_err", 32'(err_md), 32'd0);

        // Space skipping with idle gaps
        reset_dut();
        s       = "( 7 )";
        exp_out = "00001";
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            chk($sformatf("sp_out[%0d]", i), 32'(out_sp), (exp_out[i] == "1") ? 32'd1 : 32'd0);
            chk($sformatf("sp_depth[%0d]", i), 32'(depth_sp), (i < 4) ? 32'd1 : 32'd0);
            idle(2);
            chk($sformatf("sp_hold_depth[%0d]", i), 32'(depth_sp), (i < 4) ? 32'd1 : 32'd0);
        end
        chk("sp_err", 32'(err_sp), 32'd0);
        chk("nosp_err", 32'(err_def), 32'd1);
        chk("nosp_errpos", 32'(ep_def), 32'd1);

        // Space between digits is still one operand when multi-digit is off? No: digit after digit errors
        reset_dut();
        send("1"); send(" "); send("2");
        chk("sp_digit_err", 32'(err_sp), 32'd1);
        chk("sp_digit_errpos", 32'(ep_sp), 32'd2);

        // clr together with a valid character drops the character
        reset_dut();
        send("("); send("1"); send("+");
        clr      = 1'b1;
        in_valid = 1'b1;
        in       = "(";
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clrv_depth", 32'(depth_def), 32'd0);
        chk("clrv_out", 32'(out_def), 32'd0);
        chk("clrv_err", 32'(err_def), 32'd0);
        send("5");
        chk("clrv_out5", 32'(out_def), 32'd1);

        // Trailing operator and empty parens
        reset_dut();
        send("1"); send("+");
        chk("trail_out", 32'(out_def), 32'd0);
        chk("trail_err", 32'(err_def), 32'd0);
        reset_dut();
        send("("); send(")");
        chk("empty_par_err", 32'(err_def), 32'd1);
        chk("empty_par_pos", 32'(ep_def), 32'd1);

        // Position counter saturates at 255
        reset_dut();
        send("1");
        for (int i = 0; i < 150; i++) begin
            send("+");
            send("1");
        end
        chk("sat_noerr", 32'(err_def), 32'd0);
        chk("sat_out", 32'(out_def), 32'd1);
        send(")");
        chk("sat_err", 32'(err_def), 32'd1);
        chk("sat_errpos", 32'(ep_def), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
